// File: rtl/cont_display_driver.sv
`default_nettype none
// ============================================================================
//  Module   : cont_display_driver
//  Purpose  : Samples a 4-bit triangle counter (0..15..0) every clock, splits
//             the value into two decimal digits (00-15) and scans them onto a
//             two-digit common-anode 7-segment display. Also reports the
//             counting direction and a one-cycle turnaround pulse.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    REFRESH_DIV   : clock cycles each digit stays lit (>= 2)
//    BLANK_LEADING : 1 blanks the tens digit when it is 0, 0 always shows it
//  Ports
//    clock   in  1 : single clock, rising edge
//    reset   in  1 : synchronous, active-high
//    cnt     in  4 : count value from the counter, 0..15
//    seg     out 7 : segments, active-low, seg[0]=a .. seg[6]=g
//    an      out 2 : digit enables, active-low, an[0]=ones, an[1]=tens
//    dir_led out 1 : 0 = counting up, 1 = counting down
//    turn    out 1 : one-cycle pulse when dir_led changes
// ============================================================================
module cont_display_driver #(
  parameter int REFRESH_DIV   = 50000,
  parameter int BLANK_LEADING = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] cnt,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       dir_led,
  output logic       turn
);

  localparam int             DW          = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DW-1:0]  c_div_last  = DW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0]  c_div_one   = DW'(1);
  localparam logic [6:0]     c_seg_blank = 7'b1111111;

  // Active-low gfedcba pattern for one decimal digit.
  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    logic [6:0] p;
    p = c_seg_blank;
    case (d)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = c_seg_blank;
    endcase
    return p;
  endfunction

  logic [3:0]    cnt_q;
  logic [3:0]    prev_q;
  logic [DW-1:0] div_cnt;
  logic          digit_sel;

  // Decimal split of the captured count.
  logic       tens;
  logic [3:0] ones;
  assign tens = (cnt_q >= 4'd10);
  assign ones = tens ? (cnt_q - 4'd10) : cnt_q;

  logic cnt_up;
  logic cnt_down;
  assign cnt_up   = (cnt_q > prev_q);
  assign cnt_down = (cnt_q < prev_q);

  // Capture and direction tracking. Plain unsigned compare: 15->0 is down.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= 4'd0;
      prev_q  <= 4'd0;
      dir_led <= 1'b0;
      turn    <= 1'b0;
    end else begin
      cnt_q  <= cnt;
      prev_q <= cnt_q;
      if (cnt_up) begin
        dir_led <= 1'b0;
        turn    <= dir_led;      // pulse only if we were counting down
      end else if (cnt_down) begin
        dir_led <= 1'b1;
        turn    <= ~dir_led;     // pulse only if we were counting up
      end else begin
        turn    <= 1'b0;
      end
    end
  end

  // Refresh divider: digit_sel flips once every REFRESH_DIV cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt   <= '0;
      digit_sel <= 1'b0;
    end else if (div_cnt == c_div_last) begin
      div_cnt   <= '0;
      digit_sel <= ~digit_sel;
    end else begin
      div_cnt   <= div_cnt + c_div_one;
    end
  end

  // Registered display outputs, built from the current digit_sel and cnt_q,
  // so a digit switch reaches the pins one cycle after digit_sel toggles.
  always_ff @(posedge clock) begin
    if (reset) begin
      seg <= c_seg_blank;
      an  <= 2'b11;
    end else if (!digit_sel) begin
      an  <= 2'b10;
      seg <= seg_pattern(ones);
    end else if (tens) begin
      an  <= 2'b01;
      seg <= seg_pattern(4'd1);
    end else if (BLANK_LEADING != 0) begin
      an  <= 2'b11;
      seg <= c_seg_blank;
    end else begin
      an  <= 2'b01;
      seg <= seg_pattern(4'd0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cont_display_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cont_display_driver
//  Purpose  : Directed self-checking bench for cont_display_driver. Three
//             instances share clock/reset/cnt:
//               dut  : REFRESH_DIV=4, BLANK_LEADING=1
//               dutn : REFRESH_DIV=4, BLANK_LEADING=0
//               dut8 : REFRESH_DIV=8, BLANK_LEADING=1
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cont_display_driver;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] cnt   = 4'd0;

  logic [6:0] seg,  segn,  seg8;
  logic [1:0] an,   ann,   an8;
  logic       dir,  dirn,  dir8;
  logic       turn, turnn, turn8;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  cont_display_driver #(.REFRESH_DIV(4), .BLANK_LEADING(1)) dut (
    .clock(clock), .reset(reset), .cnt(cnt),
    .seg(seg), .an(an), .dir_led(dir), .turn(turn));

  cont_display_driver #(.REFRESH_DIV(4), .BLANK_LEADING(0)) dutn (
    .clock(clock), .reset(reset), .cnt(cnt),
    .seg(segn), .an(ann), .dir_led(dirn), .turn(turnn));

  cont_display_driver #(.REFRESH_DIV(8), .BLANK_LEADING(1)) dut8 (
    .clock(clock), .reset(reset), .cnt(cnt),
    .seg(seg8), .an(an8), .dir_led(dir8), .turn(turn8));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Triangle sweep 0..15..0,1, then hold 1.
  function automatic logic [3:0] tri_val(input int k);
    if (k <= 15)      return 4'(k);
    else if (k <= 30) return 4'(30 - k);
    else              return 4'd1;
  endfunction

  initial begin
    // ---------------- Reset held 3 cycles with cnt=9 ----------------
    reset = 1'b1;
    cnt   = 4'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_seg",  8'(seg),  8'h7F);
      chk("rst_an",   8'(an),   8'h03);
      chk("rst_dir",  8'(dir),  8'h00);
      chk("rst_turn", 8'(turn), 8'h00);
    end
    chk("rst_segn", 8'(segn), 8'h7F);
    chk("rst_seg8", 8'(seg8), 8'h7F);
    chk("rst_an8",  8'(an8),  8'h03);

    // ---------------- Two-digit scan, cnt=13, DIV=4 ----------------
    // Edge 1 shows the reset cnt_q (0); ones of 13 on edges 2-4,
    // tens on 5-8, ones on 9-12.
    reset = 1'b0;
    cnt   = 4'd13;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1) begin
        chk("scan_first_seg", 8'(seg), 8'h40);
        chk("scan_first_an",  8'(an),  8'h02);
      end else if (((k - 1) / 4) % 2 == 0) begin
        chk("scan_ones_seg", 8'(seg), 8'h30);
        chk("scan_ones_an",  8'(an),  8'h02);
      end else begin
        chk("scan_tens_seg", 8'(seg), 8'h79);
        chk("scan_tens_an",  8'(an),  8'h01);
      end
      chk("scan_turn", 8'(turn), 8'h00);
    end

    // ---------------- Mid-scan reset, then cnt=7 blanking ----------------
    tick();                                   // edge 13: tens slot
    chk("mid_pre_an", 8'(an), 8'h01);
    reset = 1'b1;
    tick();                                   // edge 14: reset
    chk("mid_rst_seg",  8'(seg),  8'h7F);
    chk("mid_rst_an",   8'(an),   8'h03);
    chk("mid_rst_dir",  8'(dir),  8'h00);
    chk("mid_rst_turn", 8'(turn), 8'h00);
    chk("mid_rst_segn", 8'(segn), 8'h7F);
    reset = 1'b0;
    cnt   = 4'd7;
    tick();                                   // edge 15: restart on ones (0)
    chk("restart_seg", 8'(seg), 8'h40);
    chk("restart_an",  8'(an),  8'h02);
    tick();                                   // edge 16: ones of 7
    chk("b7_ones_seg",  8'(seg),  8'h78);
    chk("b7_ones_an",   8'(an),   8'h02);
    chk("b7_ones_segn", 8'(segn), 8'h78);
    tick();
    tick();                                   // edge 18: still ones
    chk("b7_e18_an", 8'(an), 8'h02);
    tick();                                   // edge 19: tens slot
    chk("blank_an",    8'(an),   8'h03);
    chk("blank_seg",   8'(seg),  8'h7F);
    chk("noblank_an",  8'(ann),  8'h01);
    chk("noblank_seg", 8'(segn), 8'h40);
    chk("div8_ones_an",  8'(an8),  8'h02);
    chk("div8_ones_seg", 8'(seg8), 8'h78);
    tick(); tick(); tick();                   // edges 20-22: tens slot
    chk("blank_e22_an", 8'(an), 8'h03);
    tick();                                   // edge 23: back to ones
    chk("b7_back_seg",  8'(seg),  8'h78);
    chk("b7_back_an",   8'(an),   8'h02);
    chk("b7_back_segn", 8'(segn), 8'h78);
    chk("b7_back_ann",  8'(ann),  8'h02);

    // ---------------- Triangle sweep ----------------
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k <= 33; k++) begin
      logic ed;
      logic et;
      cnt = tri_val(k);
      tick();
      ed = (k >= 17 && k <= 31);
      et = (k == 17 || k == 32);
      chk("sweep_dir",   8'(dir),   8'(ed));
      chk("sweep_turn",  8'(turn),  8'(et));
      chk("sweep_dirn",  8'(dirn),  8'(ed));
      chk("sweep_turn8", 8'(turn8), 8'(et));
      chk("sweep_dir8",  8'(dir8),  8'(ed));
      chk("sweep_turnn", 8'(turnn), 8'(et));
    end

    // ---------------- Stall: rise to 6, hold 20 cycles ----------------
    for (int v = 2; v <= 6; v++) begin
      cnt = 4'(v);
      tick();
      chk("rise_dir",  8'(dir),  8'h00);
      chk("rise_turn", 8'(turn), 8'h00);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("stall_dir",  8'(dir),  8'h00);
      chk("stall_turn", 8'(turn), 8'h00);
    end

    // ---------------- Latency, DIV=8, ones selected ----------------
    reset = 1'b1;
    cnt   = 4'd2;
    tick();
    chk("lat_rst_seg8", 8'(seg8), 8'h7F);
    reset = 1'b0;
    tick();                                   // L1: shows reset cnt_q
    chk("lat_l1_seg8", 8'(seg8), 8'h40);
    tick();                                   // L2: shows 2
    chk("lat_l2_seg8", 8'(seg8), 8'h24);
    chk("lat_l2_an8",  8'(an8),  8'h02);
    cnt = 4'd11;                              // change at edge t = L2
    tick();                                   // t+1: not yet
    chk("lat_t1_seg8", 8'(seg8), 8'h24);
    tick();                                   // t+2: ones of 11
    chk("lat_t2_seg8", 8'(seg8), 8'h79);
    chk("lat_t2_an8",  8'(an8),  8'h02);
    tick();
    chk("lat_t3_seg8", 8'(seg8), 8'h79);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cont_display_driver.md
# cont_display_driver

Downstream consumer of the 4-bit triangle counter (0..15..0). It samples the count every clock and converts it to two decimal digits (00–15). It drives a time-multiplexed two-digit common-anode 7-segment display and reports the counting direction as a status LED plus a one-cycle turnaround pulse. It sits between the counter and the board display pins.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit stays lit; legal range ≥ 2.
- `BLANK_LEADING`, default 1: 1 blanks the tens digit when it is 0; 0 always shows it.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `cnt` in 4: count value from the counter, unsigned 0..15.
- `seg` out 7: segments, active-low; `seg[0]`=a … `seg[6]`=g.
- `an` out 2: digit enables, active-low; `an[0]`=ones, `an[1]`=tens.
- `dir_led` out 1: 0 = counting up, 1 = counting down.
- `turn` out 1: one-cycle pulse when `dir_led` changes.

## Operation
- **Capture and compare.** `cnt_q` <= `cnt` every cycle. `prev_q` <= `cnt_q` every cycle. Direction is derived by comparing `cnt_q` with `prev_q`.
- **Direction.**
  - `cnt_q > prev_q`: `dir_led` <= 0.
  - `cnt_q < prev_q`: `dir_led` <= 1.
  - Equal: `dir_led` holds.
  - Comparison is unsigned 4-bit with no wrap interpretation: 15→0 counts as down, 0→15 counts as up.
- **Turnaround pulse.** `turn` <= 1 for exactly one cycle in the same cycle that `dir_led` takes a new value, otherwise 0.
- **Decimal split (combinational from `cnt_q`).**
  - `tens` = (`cnt_q` ≥ 10).
  - `ones` = `cnt_q` − 10 when `tens` = 1, else `cnt_q`.
  - `ones` is 4 bits, always 0..9.
- **Refresh divider.**
  - `div_cnt` is $clog2(REFRESH_DIV) bits wide and counts 0..REFRESH_DIV−1, then wraps to 0.
  - On the cycle `div_cnt` == REFRESH_DIV−1, `digit_sel` toggles.
  - `digit_sel` = 0 selects ones; `digit_sel` = 1 selects tens.
- **Output register (`seg`, `an`, from `digit_sel` and current `cnt_q`).**
  - `digit_sel` = 0: `an` = 2'b10, `seg` = pattern(`ones`).
  - `digit_sel` = 1 and `tens` = 1: `an` = 2'b01, `seg` = pattern(1).
  - `digit_sel` = 1, `tens` = 0, BLANK_LEADING = 1: `an` = 2'b11, `seg` = 7'b1111111.
  - `digit_sel` = 1, `tens` = 0, BLANK_LEADING = 0: `an` = 2'b01, `seg` = pattern(0).
- **Patterns (`seg[6:0]` = gfedcba, active-low).**
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - Unreachable codes drive 1111111.
- **Reset.** When `reset` is high at a clock edge, all state returns to reset values on that edge. This includes reset asserted mid-refresh or mid-count; no partial digit is carried over.

## Timing
- **Reset values:**
  - `seg` = 7'b1111111, `an` = 2'b11, `dir_led` = 0, `turn` = 0.
  - `cnt_q` = 0, `prev_q` = 0, `div_cnt` = 0, `digit_sel` = 0.
- **Display latency.** A change on `cnt` at edge t is in `cnt_q` after edge t+1. It appears on `seg`/`an` after edge t+2, provided the affected digit is selected.
- **Direction latency.** `dir_led` and `turn` update after edge t+2 for a `cnt` change at edge t. `turn` deasserts after edge t+3.
- **Digit dwell.** Each digit is lit for exactly REFRESH_DIV cycles. The full scan period is 2·REFRESH_DIV cycles.
- **Digit switch.** `an` switches one cycle after `digit_sel` toggles. There is no blanking gap between digits.
- **First display after reset release.** The first edge with `reset` = 0 loads `cnt_q`, and `seg`/`an` show the ones digit of the current `cnt_q` at the same edge. `seg`/`an` therefore present the previous (reset) `cnt_q` value of 0 one cycle before the sampled value.
- **Throughput.** A new `cnt` is accepted every cycle; there is no handshake.

## Test plan
1. **Reset.** Hold `reset` = 1 for 3 cycles with `cnt` = 9 → `seg` = 1111111, `an` = 11, `dir_led` = 0, `turn` = 0. Then reassert `reset` for 1 cycle mid-scan → all outputs at reset values on that edge, and the scan restarts on ones.
2. **Two-digit scan.** REFRESH_DIV = 4, `cnt` = 13 held → `an` = 10 with `seg` = 0110000 for 4 cycles, then `an` = 01 with `seg` = 1111001 for 4 cycles, repeating.
3. **Leading-zero blanking.** `cnt` = 7 held.
   - BLANK_LEADING = 1 → tens slot shows `an` = 11, `seg` = 1111111.
   - BLANK_LEADING = 0 → tens slot shows `an` = 01, `seg` = 1000000.
   - Ones slot shows `seg` = 1111000 in both cases.
4. **Triangle sweep.** Drive 0,1,…,15,14,…,0,1 at one step per cycle.
   - `dir_led` = 0 while rising.
   - `dir_led` goes 1 two edges after 14 (following 15) is applied, with `turn` = 1 for exactly that cycle.
   - The next `turn` fires two edges after 1 (following 0) is applied, and `dir_led` returns to 0.
5. **Stall.** Sweep up to 6, then hold `cnt` = 6 for 20 cycles → `dir_led` stays 0 and `turn` stays 0 throughout.
6. **Latency.** REFRESH_DIV = 8, ones digit selected, `cnt` steps 2 → 11 at edge t → `seg` changes from 0100100 to 1111001 exactly at edge t+2, not earlier.
